// File: rtl/ps2_frame_receiver.sv
// PS/2 device-to-host frame receiver: sync, glitch filter, 11-bit deserialiser, E0/F0 prefix stripping.
// Build option: define PS2_PARITY_CHECK_EN to discard frames whose odd parity does not match.
module ps2_frame_receiver #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] scan_code,
    output logic       key_action,
    output logic       key_break,
    output logic       key_extended,
    output logic       frame_err,
    output logic       busy
);
    localparam int              TO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_MAX   = TO_W'(TIMEOUT_CYCLES);
    localparam logic [3:0]      FILT_TOP = 4'(FILTER_LEN - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    // Bit 0 carries ps2_clk, bit 1 carries ps2_dat; both idle high.
    logic [1:0] pin_raw;
    logic [1:0] sync_val;
    assign pin_raw = {ps2_dat, ps2_clk};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            logic meta_reg;
            logic out_reg;
            always_ff @(posedge Clock or posedge Reset) begin
                if (Reset) begin
                    meta_reg <= 1'b1;
                    out_reg  <= 1'b1;
                end else begin
                    meta_reg <= pin_raw[gi];
                    out_reg  <= meta_reg;
                end
            end
            assign sync_val[gi] = out_reg;
        end
    endgenerate

    logic clk_s;
    logic dat_s;
    assign clk_s = sync_val[0];
    assign dat_s = sync_val[1];

    // Glitch filter: the level flips only after FILTER_LEN consecutive opposite samples.
    logic [3:0] filt_cnt_reg, filt_cnt_next;
    logic       filt_level_reg, filt_level_next;
    logic       filt_prev_reg;
    logic       fall_reg;

    always_comb begin
        filt_cnt_next   = '0;
        filt_level_next = filt_level_reg;
        if (clk_s != filt_level_reg) begin
            if (filt_cnt_reg == FILT_TOP) begin
                filt_level_next = clk_s;
            end else begin
                filt_cnt_next = filt_cnt_reg + 4'd1;
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            filt_cnt_reg   <= '0;
            filt_level_reg <= 1'b1;
            filt_prev_reg  <= 1'b1;
            fall_reg       <= 1'b0;
        end else begin
            filt_cnt_reg   <= filt_cnt_next;
            filt_level_reg <= filt_level_next;
            filt_prev_reg  <= filt_level_reg;
            fall_reg       <= filt_prev_reg & ~filt_level_reg;
        end
    end

    state_t          state_reg, state_next;
    logic [2:0]      bit_cnt_reg, bit_cnt_next;
    logic [7:0]      shift_reg, shift_next;
    logic [TO_W-1:0] timeout_reg, timeout_next;
    logic            pend_ext_reg, pend_ext_next;
    logic            pend_brk_reg, pend_brk_next;
    logic [7:0]      scan_code_reg, scan_code_next;
    logic            key_action_reg, key_action_next;
    logic            key_break_reg, key_break_next;
    logic            key_extended_reg, key_extended_next;
    logic            frame_err_reg, frame_err_next;
    logic            parity_ok;

`ifdef PS2_PARITY_CHECK_EN
    logic parity_reg, parity_next;
    assign parity_ok = ^{shift_reg, parity_reg};
`else
    assign parity_ok = 1'b1;
`endif

    always_comb begin
        state_next        = state_reg;
        bit_cnt_next      = bit_cnt_reg;
        shift_next        = shift_reg;
        timeout_next      = timeout_reg;
        pend_ext_next     = pend_ext_reg;
        pend_brk_next     = pend_brk_reg;
        scan_code_next    = scan_code_reg;
        key_action_next   = 1'b0;
        key_break_next    = key_break_reg;
        key_extended_next = key_extended_reg;
        frame_err_next    = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
        parity_next       = parity_reg;
`endif

        if (state_reg == IDLE || fall_reg) begin
            timeout_next = '0;
        end else if (timeout_reg != TO_MAX) begin
            timeout_next = timeout_reg + TO_W'(1);
        end

        // A fall in the same cycle as expiry takes priority over the timeout.
        if (fall_reg) begin
            case (state_reg)
                IDLE: begin
                    if (!dat_s) begin
                        state_next   = DATA;
                        bit_cnt_next = 3'd0;
                    end
                end
                DATA: begin
                    shift_next[bit_cnt_reg] = dat_s;
                    bit_cnt_next            = bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7) begin
                        state_next = PARITY;
                    end
                end
                PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                    parity_next = dat_s;
`endif
                    state_next = STOP;
                end
                STOP: begin
                    state_next = IDLE;
                    if (dat_s && parity_ok) begin
                        if (shift_reg == 8'hE0) begin
                            pend_ext_next = 1'b1;
                        end else if (shift_reg == 8'hF0) begin
                            pend_brk_next = 1'b1;
                        end else begin
                            key_action_next   = 1'b1;
                            scan_code_next    = shift_reg;
                            key_break_next    = pend_brk_reg;
                            key_extended_next = pend_ext_reg;
                            pend_ext_next     = 1'b0;
                            pend_brk_next     = 1'b0;
                        end
                    end else begin
                        frame_err_next = 1'b1;
                        pend_ext_next  = 1'b0;
                        pend_brk_next  = 1'b0;
                    end
                end
                default: state_next = IDLE;
            endcase
        end else if (state_reg != IDLE && timeout_reg == TO_MAX) begin
            state_next     = IDLE;
            frame_err_next = 1'b1;
            pend_ext_next  = 1'b0;
            pend_brk_next  = 1'b0;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_reg        <= IDLE;
            bit_cnt_reg      <= '0;
            shift_reg        <= '0;
            timeout_reg      <= '0;
            pend_ext_reg     <= 1'b0;
            pend_brk_reg     <= 1'b0;
            scan_code_reg    <= '0;
            key_action_reg   <= 1'b0;
            key_break_reg    <= 1'b0;
            key_extended_reg <= 1'b0;
            frame_err_reg    <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            parity_reg       <= 1'b0;
`endif
        end else begin
            state_reg        <= state_next;
            bit_cnt_reg      <= bit_cnt_next;
            shift_reg        <= shift_next;
            timeout_reg      <= timeout_next;
            pend_ext_reg     <= pend_ext_next;
            pend_brk_reg     <= pend_brk_next;
            scan_code_reg    <= scan_code_next;
            key_action_reg   <= key_action_next;
            key_break_reg    <= key_break_next;
            key_extended_reg <= key_extended_next;
            frame_err_reg    <= frame_err_next;
`ifdef PS2_PARITY_CHECK_EN
            parity_reg       <= parity_next;
`endif
        end
    end

    assign scan_code    = scan_code_reg;
    assign key_action   = key_action_reg;
    assign key_break    = key_break_reg;
    assign key_extended = key_extended_reg;
    assign frame_err    = frame_err_reg;
    assign busy         = (state_reg != IDLE);

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Testbench for ps2_frame_receiver: directed and random PS/2 frames against a frame-level model.
module tb_ps2_frame_receiver;
    localparam int FILTER_LEN = 4;
    localparam int TB_TIMEOUT = 1000;
    localparam int HALF       = 12;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic [7:0] scan_code;
    logic       key_action, key_break, key_extended, frame_err, busy;

    ps2_frame_receiver #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
        .Clock(Clock), .Reset(Reset), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
        .scan_code(scan_code), .key_action(key_action), .key_break(key_break),
        .key_extended(key_extended), .frame_err(frame_err), .busy(busy)
    );

    always #5 Clock = ~Clock;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int stop_fall_cyc = 0;

    always @(posedge Clock) cyc <= cyc + 1;

    // Observed events and model expectations ({brk, ext, code})
    logic [9:0] key_q[$];
    int         key_cyc_q[$];
    int         err_cnt = 0;
    logic [9:0] exp_key_q[$];
    int         exp_errs = 0;
    logic       m_ext = 1'b0;
    logic       m_brk = 1'b0;
    logic [7:0] last_code = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge Clock) begin
        if (key_action === 1'b1) begin
            key_q.push_back({key_break, key_extended, scan_code});
            key_cyc_q.push_back(cyc);
        end
        if (frame_err === 1'b1) err_cnt++;
        if (key_action === 1'b1 || frame_err === 1'b1)
            chk("action/err exclusive", {31'd0, key_action & frame_err}, 32'd0);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    function automatic logic [10:0] mk(input logic [7:0] d, input logic par_bad, input logic stop);
        logic p;
        p = ~(^d) ^ par_bad;
        return {stop, p, d, 1'b0};
    endfunction

    // f[0]=start, f[8:1]=data, f[9]=parity, f[10]=stop; optional short low glitch before bit glitch_at
    task automatic send_bits(input logic [10:0] f, input int nbits, input int glitch_at);
        for (int i = 0; i < nbits; i++) begin
            ps2_dat = f[i];
            if (i == glitch_at) begin
                tick(7);
                ps2_clk = 1'b0;
                tick(2);
                ps2_clk = 1'b1;
                tick(HALF - 9);
            end else begin
                tick(HALF);
            end
            ps2_clk = 1'b0;
            if (i == 10) stop_fall_cyc = cyc;
            tick(HALF);
            ps2_clk = 1'b1;
        end
    endtask

    // Frame-level reference: framing rule, optional odd parity, prefix bookkeeping.
    task automatic model_frame(input logic [10:0] f);
        logic [7:0] d;
        bit good;
        d = f[8:1];
        good = (f[0] == 1'b0) && (f[10] == 1'b1);
`ifdef PS2_PARITY_CHECK_EN
        good = good && (($countones(f[9:1]) % 2) == 1);
`endif
        if (!good) begin
            exp_errs++;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else if (d == 8'hE0) begin
            m_ext = 1'b1;
        end else if (d == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            exp_key_q.push_back({m_brk, m_ext, d});
            last_code = d;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic frame(input logic [7:0] d, input logic par_bad, input logic stop, input int g);
        logic [10:0] f;
        f = mk(d, par_bad, stop);
        send_bits(f, 11, g);
        ps2_dat = 1'b1;
        model_frame(f);
        tick(2 * HALF);
    endtask

    task automatic verify(input string tag);
        chk({tag, " key count"}, key_q.size(), exp_key_q.size());
        chk({tag, " err count"}, err_cnt, exp_errs);
        while (key_q.size() > 0 && exp_key_q.size() > 0)
            chk({tag, " key fields"}, {22'd0, key_q.pop_front()}, {22'd0, exp_key_q.pop_front()});
        chk({tag, " scan_code hold"}, {24'd0, scan_code}, {24'd0, last_code});
        chk({tag, " busy idle"}, {31'd0, busy}, 32'd0);
        key_q.delete();
        key_cyc_q.delete();
        exp_key_q.delete();
        err_cnt = 0;
        exp_errs = 0;
    endtask

    initial begin
        int r;
        logic [7:0] d;
        int g;

        tick(3);
        chk("reset outputs", {19'd0, scan_code, key_action, key_break, key_extended, frame_err, busy}, 32'd0);
        Reset = 1'b0;
        tick(10);

        // Glitch on an idle line
        ps2_clk = 1'b0;
        tick(2);
        ps2_clk = 1'b1;
        tick(20);
        verify("idle glitch");

        // Reset in the middle of a frame
        send_bits(mk(8'h55, 1'b0, 1'b1), 4, -1);
        chk("busy mid-frame", {31'd0, busy}, 32'd1);
        Reset = 1'b1;
        tick(1);
        chk("mid reset outputs", {19'd0, scan_code, key_action, key_break, key_extended, frame_err, busy}, 32'd0);
        tick(2);
        Reset = 1'b0;
        ps2_dat = 1'b1;
        m_ext = 1'b0;
        m_brk = 1'b0;
        last_code = 8'h00;
        tick(20);
        verify("reset mid-frame");

        frame(8'h1C, 1'b0, 1'b1, -1);
        chk("latency", (key_cyc_q.size() > 0) ? key_cyc_q[0] - stop_fall_cyc : -1, 32'd8);
        verify("make 1C");

        frame(8'hF0, 1'b0, 1'b1, -1);
        frame(8'h1C, 1'b0, 1'b1, -1);
        verify("break 1C");

        frame(8'hE0, 1'b0, 1'b1, -1);
        frame(8'hF0, 1'b0, 1'b1, -1);
        frame(8'h75, 1'b0, 1'b1, -1);
        verify("ext break 75");
        frame(8'h29, 1'b0, 1'b1, -1);
        verify("plain 29");

        frame(8'h1C, 1'b1, 1'b1, -1);
        verify("bad parity");
        frame(8'hE0, 1'b0, 1'b1, -1);
        frame(8'h29, 1'b0, 1'b0, -1);
        frame(8'h29, 1'b0, 1'b1, -1);
        verify("bad stop clears prefix");

        // Start bit of 1 is ignored silently
        send_bits(11'h7FF, 1, -1);
        tick(2 * HALF);
        verify("bad start");

        // Timeout after 5 bits, with a pending E0 that must be dropped
        frame(8'hE0, 1'b0, 1'b1, -1);
        send_bits(mk(8'h33, 1'b0, 1'b1), 5, -1);
        tick(TB_TIMEOUT - 50);
        chk("busy before timeout", {31'd0, busy}, 32'd1);
        chk("no err before timeout", err_cnt, 32'd0);
        tick(60);
        exp_errs++;
        m_ext = 1'b0;
        m_brk = 1'b0;
        verify("timeout");
        frame(8'h29, 1'b0, 1'b1, -1);
        verify("after timeout");

        frame(8'h1B, 1'b0, 1'b1, 5);
        verify("mid-frame glitch");

        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 9);
            d = 8'($urandom);
            if (r == 0) d = 8'hE0;
            if (r == 1) d = 8'hF0;
            g = (r == 4) ? $urandom_range(0, 10) : -1;
            frame(d, r == 2, r != 3, g);
            if (r > 1) verify("random");
        end
        verify("random tail");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ps2_frame_receiver.md
Name: ps2_frame_receiver

Overview:
Upstream stage of the keyboard path. Samples the raw PS/2 clock and data pins and deserialises device-to-host frames. Strips the E0 (extended) and F0 (break) prefix bytes and presents each completed key code as a 1-cycle `key_action` pulse with `scan_code` and qualifier flags. Its outputs drive the scancode-to-ASCII converter directly: `key_action` to `key_action`, `scan_code` to `scan_code`.

Parameters:
- FILTER_LEN, 4: consecutive identical synchronised samples required before the filtered ps2_clk level changes (range 2..15).
- TIMEOUT_CYCLES, 50000: Clock cycles with no filtered ps2_clk falling edge before a partial frame is aborted (about 1 ms at 50 MHz).

Ports:
- Clock  input  1  system clock; all logic on posedge.
- Reset  input  1  asynchronous, active-high reset.
- ps2_clk  input  1  raw PS/2 clock pin, asynchronous to Clock.
- ps2_dat  input  1  raw PS/2 data pin, asynchronous to Clock.
- scan_code  output  8  last emitted key code (prefixes stripped).
- key_action  output  1  1-cycle pulse: scan_code/key_break/key_extended valid.
- key_break  output  1  emitted code was preceded by F0 (key release).
- key_extended  output  1  emitted code was preceded by E0.
- frame_err  output  1  1-cycle pulse: frame discarded (bad start/stop/parity or timeout).
- busy  output  1  high while a frame is in progress (state != IDLE).

Behaviour:
- Reset (async, active-high): all outputs 0; state IDLE; bit counter, shift register, timeout counter and pending E0/F0 flags cleared. Reset mid-frame discards the partial frame silently, with no frame_err.
- Input conditioning:
  - ps2_clk and ps2_dat each pass through a 2-flop synchroniser.
  - The synchronised ps2_clk feeds a saturating glitch filter. The filtered level flips only after FILTER_LEN consecutive samples of the opposite level.
  - A falling edge is a filtered 1->0 transition, registered as a 1-cycle strobe `fall`.
  - ps2_dat is sampled (synchronised value) on the `fall` strobe.
- Frame format: start 0, D0..D7 LSB first, odd parity, stop 1. That is 11 falling edges.
- FSM, advancing only on `fall` except for the timeout:
  - IDLE: sampled 0 -> DATA, bit counter = 0. Sampled 1 -> stay IDLE, no error.
  - DATA: shift the sampled bit into bit[counter]. After the 8th bit -> PARITY.
  - PARITY: store the parity bit -> STOP.
  - STOP: sampled 1 and parity OK -> byte accepted. Anything else -> frame_err pulse. Either way -> IDLE.
- Timeout:
  - The counter resets on every `fall` and while in IDLE.
  - Reaching TIMEOUT_CYCLES in any non-IDLE state -> IDLE, frame_err pulse, frame discarded.
  - The counter width is clog2(TIMEOUT_CYCLES+1) and it saturates.
- Accepted-byte handling:
  - 0xE0 sets pending_ext. 0xF0 sets pending_brk. Neither produces key_action.
  - Any other byte (including 0xE1 and 0xAA) is emitted. On the cycle after the stop-bit `fall`: key_action=1, scan_code=byte, key_break=pending_brk, key_extended=pending_ext. Both pending flags then clear.
- scan_code, key_break and key_extended hold their values until the next emit.
- Any frame_err clears pending_ext and pending_brk.
- Latency from the ps2_clk pin falling edge (stop bit) to key_action: 2 (sync) + FILTER_LEN (filter) + 1 (edge) + 1 (output reg) Clock cycles. That is 8 at the default.
- Simultaneous events: a `fall` and timeout expiry in the same cycle: the `fall` wins and the counter resets. key_action and frame_err are never high together.
- busy goes high on the cycle the FSM leaves IDLE and goes low on the cycle it returns.
- The block never drives the pins; host-to-device transmission is out of scope.

Optional Feature:
- Macro PS2_PARITY_CHECK_EN.
- Defined: odd parity is checked over D0..D7 plus the parity bit. A mismatch discards the byte, pulses frame_err and clears the pending flags.
- Undefined: the parity bit is clocked in and ignored. Only start, stop and timeout errors raise frame_err.

Test Plan:
- Reset high mid-frame (after 4 bits), release, then a full frame 0x1C (parity 0, stop 1) -> exactly one key_action, scan_code=0x1C, key_break=0, key_extended=0, no frame_err; pulse appears 8 cycles after the stop-bit pin edge.
- Frames F0, 1C -> no pulse after F0; one key_action with scan_code=0x1C, key_break=1, key_extended=0.
- Frames E0, F0, 75 -> one key_action, scan_code=0x75, key_break=1, key_extended=1; a following 0x29 frame gives key_break=0, key_extended=0.
- Frame 0x1C with parity=1 -> PS2_PARITY_CHECK_EN defined: frame_err pulse, no key_action; undefined: key_action with 0x1C. Frame with stop=0 -> frame_err in both builds.
- Send 5 bits then hold ps2_clk high for TIMEOUT_CYCLES+10 -> frame_err pulse, busy drops; then frame 0x29 -> key_action, scan_code=0x29.
- A 2-cycle low glitch on ps2_clk (FILTER_LEN=4) while idle and mid-frame -> no bit consumed; the subsequent frame 0x1B decodes correctly.
